// File: rtl/xext_bridge.sv
// External-select bus responder: buffers CPU write/read commands in a FIFO and
// replays them one at a time over a req/ack handshake with a timeout.
module xext_bridge #(
    parameter int unsigned EXT_ADDR_W = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  we,
    input  logic [2:0]            addr,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_to_rd,
    output logic                  ext_req,
    output logic                  ext_we,
    output logic [EXT_ADDR_W-1:0] ext_addr,
    output logic [31:0]           ext_wdata,
    input  logic                  ext_ack,
    input  logic [31:0]           ext_rdata
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 1 + EXT_ADDR_W + 32;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e                state_q, state_d;
    logic [ENT_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [EXT_ADDR_W-1:0] addr_q;
    logic [31:0]           rddata_q;
    logic                  ovf_q, tmo_q, rd_valid_q;
    logic [15:0]           tmo_cnt_q;
    logic                  ext_we_q;
    logic [EXT_ADDR_W-1:0] ext_addr_q;
    logic [31:0]           ext_wdata_q;

    logic acc_wr, acc_rd, push, push_ok, empty, full, load, tmo_hit, ack_hit;
    logic status_wr, rddata_rd, is_wdata;
    logic [ENT_W-1:0] head, new_entry;

    assign acc_wr    = sel & we;
    assign acc_rd    = sel & ~we;
    assign is_wdata  = (addr == 3'd1);
    assign push      = acc_wr & (is_wdata | (addr == 3'd3));
    assign status_wr = acc_wr & (addr == 3'd2);
    assign rddata_rd = acc_rd & (addr == 3'd4);
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_ok   = push & ~full;
    // The head leaves the FIFO as soon as it is latched into the ext_* registers.
    assign load      = (state_q == StIdle) & ~empty;
    assign ack_hit   = (state_q == StReq) & ext_ack;
    assign head      = mem[rd_ptr_q];
    assign new_entry = {is_wdata, addr_q, (is_wdata ? data_in : 32'h0)};

    assign ext_req   = (state_q == StReq);
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;

    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        unique case (state_q)
            StIdle: if (!empty) state_d = StReq;
            StReq: begin
                if (ext_ack) begin
                    state_d = StDone;
                end else if (tmo_cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d = StDone;
                    tmo_hit = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= new_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            rddata_q    <= '0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            tmo_cnt_q   <= '0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (acc_wr && addr == 3'd0) addr_q <= data_in[EXT_ADDR_W-1:0];
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, load})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            if (load) begin
                {ext_we_q, ext_addr_q, ext_wdata_q} <= head;
                tmo_cnt_q <= '0;
            end else if (state_q == StReq) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (push && full) ovf_q <= 1'b1;
            else if (status_wr) ovf_q <= 1'b0;
            if (tmo_hit) tmo_q <= 1'b1;
            else if (status_wr) tmo_q <= 1'b0;
            if (ack_hit && !ext_we_q) begin
                rddata_q   <= ext_rdata;
                rd_valid_q <= 1'b1;
            end else if (rddata_rd) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        data_to_rd = '0;
        if (acc_rd) begin
            case (addr)
                3'd0: data_to_rd[EXT_ADDR_W-1:0] = addr_q;
                3'd2: begin
                    data_to_rd[0]           = empty;
                    data_to_rd[1]           = full;
                    data_to_rd[2]           = (state_q != StIdle);
                    data_to_rd[3]           = ovf_q;
                    data_to_rd[4]           = tmo_q;
                    data_to_rd[5]           = rd_valid_q;
                    data_to_rd[8 +: CNT_W]  = count_q;
                end
                3'd4:    data_to_rd = rddata_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xext_bridge.sv
// Directed bench for xext_bridge: a queue-based model predicts every external
// request cycle, plus literal checks at the key points of each scenario.
module tb_xext_bridge;

    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    logic          we = 1'b0;
    logic [2:0]    addr = 3'd0;
    logic [31:0]   data_in = 32'h0;
    logic [31:0]   data_to_rd;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [31:0]   ext_wdata;
    logic          ext_ack = 1'b0;
    logic [31:0]   ext_rdata = 32'h0;

    xext_bridge #(.EXT_ADDR_W(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
        .data_to_rd(data_to_rd), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } cmd_t;

    cmd_t          pend[$];
    cmd_t          cur;
    bit            m_active = 0;
    int            age = 0;
    int            free_at = 0;
    int            cyc = 0;
    bit            popped_last = 0, tmo_set_last = 0, rdv_set_last = 0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_rddata = '0;
    bit            m_ovf = 0, m_tmo = 0, m_rdv = 0;

    // A finished command leaves req low for two cycles before the next one may start.
    always @(negedge clk) begin
        cyc++;
        popped_last  = 0;
        tmo_set_last = 0;
        rdv_set_last = 0;
        if (rst) begin
            pend.delete();
            m_active = 0; free_at = 0; m_addr = '0; m_rddata = '0;
            m_ovf = 0; m_tmo = 0; m_rdv = 0;
        end else begin
            chk("ext_req", 32'(ext_req), 32'(m_active));
            if (m_active) begin
                chk("ext_we", 32'(ext_we), 32'(cur.w));
                chk("ext_addr", 32'(ext_addr), 32'(cur.a));
                chk("ext_wdata", ext_wdata, cur.d);
                if (ext_ack) begin
                    if (!cur.w) begin
                        m_rddata = ext_rdata; m_rdv = 1; rdv_set_last = 1;
                    end
                    m_active = 0; free_at = cyc + 3;
                end else if (age + 1 == int'(TMO)) begin
                    m_tmo = 1; tmo_set_last = 1; m_active = 0; free_at = cyc + 3;
                end else begin
                    age++;
                end
            end else if (cyc >= free_at - 1 && pend.size() > 0) begin
                cur = pend.pop_front(); m_active = 1; age = 0; popped_last = 1;
            end
        end
    end

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        int n;
        n = pend.size();
        s = '0;
        s[0] = (n == 0);
        s[1] = (n == int'(DEPTH));
        s[2] = m_active || (cyc + 1 < free_at - 1);
        s[3] = m_ovf;
        s[4] = m_tmo;
        s[5] = m_rdv;
        s[12:8] = 5'(n);
        return s;
    endfunction

    task automatic model_push(input logic w, input logic [31:0] d);
        cmd_t c;
        c.w = w; c.a = m_addr; c.d = w ? d : 32'h0;
        // The DUT's occupancy at this edge still includes an entry being loaded now.
        if (pend.size() + int'(popped_last) >= int'(DEPTH)) m_ovf = 1;
        else pend.push_back(c);
    endtask

    // ---------------- request timing observer ----------------
    int   hi_cnt = 0, lo_cnt = 0, hi_len = 0, gap_len = 0, rises = 0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            hi_cnt = 0; lo_cnt = 0; req_prev = 1'b0; rises = 0;
        end else begin
            if (ext_req) begin
                if (!req_prev) begin gap_len = lo_cnt; hi_cnt = 0; rises++; end
                hi_cnt++;
            end else begin
                if (req_prev) begin hi_len = hi_cnt; lo_cnt = 0; end
                lo_cnt++;
            end
            req_prev = ext_req;
        end
    end

    // ---------------- external responder ----------------
    int          ack_delay = 0;
    logic [31:0] ack_rdata = 32'h0;
    logic        ack_pr = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (ext_req && !ack_pr && !rst && ack_delay > 0) begin
                ack_pr = 1'b1;
                repeat (ack_delay) @(posedge clk);
                #1 ext_ack = 1'b1; ext_rdata = ack_rdata;
                @(posedge clk);
                #1 ext_ack = 1'b0;
            end else begin
                ack_pr = ext_req;
            end
        end
    end

    // ---------------- CPU access tasks (enter and leave at posedge+1) ----------------
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        case (a)
            3'd0: m_addr = d[AW-1:0];
            3'd1: model_push(1'b1, d);
            3'd2: begin m_ovf = 0; if (!tmo_set_last) m_tmo = 0; end
            3'd3: model_push(1'b0, d);
            default: ;
        endcase
        #1 sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        sel = 1'b1; we = 1'b0; addr = a;
        #1 chk(name, data_to_rd, exp);
        @(posedge clk);
        if (a == 3'd4 && !rdv_set_last) m_rdv = 0;
        #1 sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic lvl, input int lim, input string name);
        int k = 0;
        bit ok = 0;
        while (!ok && k < lim) begin
            @(negedge clk);
            k++;
            if (ext_req === lvl) ok = 1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: ext_req not %0b within %0d cycles", name, lvl, lim);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rd_without_sel", data_to_rd, 32'h0);
        rd(3'd2, 32'h0000_0001, "status_reset");
        chk("ext_req_reset", 32'(ext_req), 32'h0);
        rd(3'd4, 32'h0, "rddata_reset");
        rd(3'd0, 32'h0, "addr_reset");

        // External write
        ack_delay = 3; ack_rdata = 32'h0BAD_0BAD;
        wr(3'd0, 32'hFFFF_1234);
        rd(3'd0, 32'h0000_1234, "addr_upper_bits_masked");
        rd(3'd5, 32'h0, "unmapped_read");
        wr(3'd1, 32'hDEAD_BEEF);
        wait_req(1'b1, 10, "wr_issue");
        chk("wr_ext_we", 32'(ext_we), 32'h1);
        chk("wr_ext_addr", 32'(ext_addr), 32'h1234);
        chk("wr_ext_wdata", ext_wdata, 32'hDEAD_BEEF);
        rd(3'd2, 32'h0000_0005, "status_busy");
        wait_req(1'b0, 10, "wr_done");
        rd(3'd2, 32'h0000_0001, "status_after_wr");

        // External read; ADDR rewritten right after the push must not alter the entry
        ack_rdata = 32'hCAFE_F00D;
        wr(3'd0, 32'h0000_0042);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd0, 32'h0000_0077);
        wait_req(1'b1, 10, "rd_issue");
        chk("rd_ext_we", 32'(ext_we), 32'h0);
        chk("rd_ext_addr", 32'(ext_addr), 32'h0042);
        chk("rd_ext_wdata", ext_wdata, 32'h0);
        wait_req(1'b0, 10, "rd_done");
        rd(3'd2, 32'h0000_0021, "status_rd_valid");
        rd(3'd4, 32'hCAFE_F00D, "rddata");
        rd(3'd2, 32'h0000_0001, "status_rd_valid_cleared");
        rd(3'd4, m_rddata, "rddata_model");

        // Overflow with ack withheld
        ack_delay = 0;
        for (int i = 1; i <= 5; i++) wr(3'd1, 32'(i));
        rd(3'd2, 32'h0000_0406, "status_full");
        wr(3'd1, 32'h6);
        rd(3'd2, 32'h0000_040E, "status_ovf");
        wr(3'd2, 32'h0);
        rd(3'd2, 32'h0000_0406, "status_ovf_cleared");
        rd(3'd2, m_status(), "status_model");

        // Timeout of the first entry, next entry follows after a two-cycle gap
        wait_req(1'b0, 300, "tmo_drop");
        wait_req(1'b1, 10, "tmo_next_issue");
        chk("tmo_req_len", 32'(hi_len), 32'd255);
        chk("tmo_gap_len", 32'(gap_len), 32'd2);
        rd(3'd2, 32'h0000_0314, "status_tmo");

        // Asynchronous reset with a request in flight and 3 entries queued
        rst = 1'b1;
        #1 chk("ext_req_async_rst", 32'(ext_req), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rd(3'd2, 32'h0000_0001, "status_after_rst");
        rd(3'd4, 32'h0, "rddata_after_rst");
        idle(20);
        chk("no_req_after_rst", 32'(rises), 32'h0);
        rd(3'd2, m_status(), "status_model_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
